// File: rtl/pipe_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_stage
// Purpose  : Parametrised inter-stage pipeline register. Carries a control
//            bundle and a payload through DEPTH register slices with
//            per-slice valid tracking, stall (hold), flush (bubble
//            injection) and a registered occupancy count.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous, active-low reset
//            stall      - hold every slice this cycle
//            flush      - invalidate every slice this cycle (beats stall)
//            valid_in   - upstream slot holds a real instruction
//            ctrl_in    - upstream control bundle [CTRL_W]
//            data_in    - upstream payload [DATA_W]
//            valid_out  - last slice valid
//            ctrl_out   - last slice control (0 whenever valid_out is 0)
//            data_out   - last slice payload
//            occupancy  - number of valid slices [$clog2(DEPTH+1)]
//            stall_cycles, bubble_cycles - saturating 32-bit performance
//            counters, present only when PIPE_PERF_CNT_EN is defined
// Options  : PIPE_PERF_CNT_EN (macro) adds the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stage #(
  parameter int CTRL_W     = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       valid_out,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [DATA_W-1:0]          data_out,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]                stall_cycles,
  output logic [31:0]                bubble_cycles,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              valid_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [OCC_W-1:0]  occ_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      occ_q <= '0;
    end else if (flush) begin
      // Every slice becomes a bubble; the instruction on the inputs is lost.
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= '0;
        if (FLUSH_DATA != 0) begin
          data_q[i] <= '0;
        end
      end
      occ_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= valid_in;
      // Mask control at capture so a bubble can never assert a write enable.
      ctrl_q[0]  <= valid_in ? ctrl_in : '0;
      data_q[0]  <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        ctrl_q[i]  <= ctrl_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
      // One entry enters at slice 0 while the last slice leaves.
      occ_q <= occ_q + OCC_W'(valid_in) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign ctrl_out  = ctrl_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (stall && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      // Counts cycles in which the downstream stage sees an empty slot.
      if (!valid_q[DEPTH-1] && (bubble_cycles != 32'hFFFF_FFFF)) begin
        bubble_cycles <= bubble_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_stage
// Purpose  : Self-checking bench for pipe_ctrl_stage. Drives a DEPTH=3,
//            FLUSH_DATA=0 instance and a DEPTH=1, FLUSH_DATA=1 instance from
//            the same stimulus and compares both against a queue model every
//            cycle, plus hand-computed literal checks.
// Options  : PIPE_PERF_CNT_EN (macro) also exercises the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_in;
  logic [3:0]  ctrl_in;
  logic [31:0] data_in;

  logic        v3, v1;
  logic [3:0]  c3, c1;
  logic [31:0] d3, d1;
  logic [1:0]  occ3;
  logic        occ1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] sc3, bc3, sc1, bc1;
`endif

  pipe_ctrl_stage #(.CTRL_W(4), .DATA_W(32), .DEPTH(3), .FLUSH_DATA(0)) u3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .valid_out(v3), .ctrl_out(c3), .data_out(d3),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(sc3), .bubble_cycles(bc3),
`endif
    .occupancy(occ3)
  );

  pipe_ctrl_stage #(.CTRL_W(4), .DATA_W(32), .DEPTH(1), .FLUSH_DATA(1)) u1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .valid_out(v1), .ctrl_out(c1), .data_out(d1),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(sc1), .bubble_cycles(bc1),
`endif
    .occupancy(occ1)
  );

  // ---------------- behavioural model ----------------
  // Each pipeline is a queue: new entries enter at the front, the back is
  // what the next stage sees.
  ent_t q3[$];
  ent_t q1[$];
  int   m_stall3, m_bub3, m_stall1, m_bub1;
  bit   model_ok = 1'b0;

  task automatic model_step(ref ent_t q[$], input int depth, input bit fd,
                            ref int st_cnt, ref int bub_cnt);
    ent_t e;
    if (!reset) begin
      q.delete();
      for (int i = 0; i < depth; i++) q.push_back('0);
      st_cnt  = 0;
      bub_cnt = 0;
    end else begin
      if (stall && !flush) st_cnt++;
      if (!q[depth-1].v) bub_cnt++;
      if (flush) begin
        for (int i = 0; i < depth; i++) begin
          q[i].v = 1'b0;
          q[i].c = 4'h0;
          if (fd) q[i].d = 32'h0;
        end
      end else if (!stall) begin
        e.v = valid_in;
        e.c = valid_in ? ctrl_in : 4'h0;
        e.d = data_in;
        q.push_front(e);
        void'(q.pop_back());
      end
    end
  endtask

  function automatic int count_valid(ent_t q[$]);
    int n = 0;
    foreach (q[i]) if (q[i].v) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    model_step(q3, 3, 1'b0, m_stall3, m_bub3);
    model_step(q1, 1, 1'b1, m_stall1, m_bub1);
    if (!reset) model_ok = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m3_valid", {31'b0, v3}, {31'b0, q3[2].v});
      check("m3_ctrl",  {28'b0, c3}, {28'b0, q3[2].c});
      check("m3_data",  d3,          q3[2].d);
      check("m3_occ",   {30'b0, occ3}, 32'(count_valid(q3)));
      check("m1_valid", {31'b0, v1}, {31'b0, q1[0].v});
      check("m1_ctrl",  {28'b0, c1}, {28'b0, q1[0].c});
      check("m1_data",  d1,          q1[0].d);
      check("m1_occ",   {31'b0, occ1}, 32'(count_valid(q1)));
`ifdef PIPE_PERF_CNT_EN
      check("m3_stallcnt", sc3, 32'(m_stall3));
      check("m3_bubcnt",   bc3, 32'(m_bub3));
      check("m1_stallcnt", sc1, 32'(m_stall1));
      check("m1_bubcnt",   bc1, 32'(m_bub1));
`endif
    end
  end

  // Apply one cycle of inputs, let the edge happen, return at the negedge.
  task automatic cyc(input logic r, input logic s, input logic f,
                     input logic v, input logic [3:0] c, input logic [31:0] d);
    reset = r; stall = s; flush = f; valid_in = v; ctrl_in = c; data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    ctrl_in = 4'h0; data_in = 32'h0;
    @(negedge clk);

    // Reset held two cycles with a valid instruction presented.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 32'hAA);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 32'hAA);
    check("rst_valid3", {31'b0, v3}, 32'h0);
    check("rst_ctrl3",  {28'b0, c3}, 32'h0);
    check("rst_data3",  d3, 32'h0);
    check("rst_occ3",   {30'b0, occ3}, 32'h0);
    check("rst_valid1", {31'b0, v1}, 32'h0);

    // Stream 1..4.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 32'd1);
    check("s1_occ3",   {30'b0, occ3}, 32'd1);
    check("s1_valid3", {31'b0, v3}, 32'h0);
    check("s1_data1",  d1, 32'd1);
    check("s1_ctrl1",  {28'b0, c1}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 32'd2);
    check("s2_occ3",   {30'b0, occ3}, 32'd2);
    check("s2_valid3", {31'b0, v3}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 32'd3);
    check("s3_occ3",   {30'b0, occ3}, 32'd3);
    check("s3_data3",  d3, 32'd1);
    check("s3_valid3", {31'b0, v3}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 32'd4);
    check("s4_occ3",   {30'b0, occ3}, 32'd3);
    check("s4_data3",  d3, 32'd2);

    // Stall two cycles while offering D=0x99: nothing moves.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 32'h99);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 32'h99);
    check("stall_data3", d3, 32'd2);
    check("stall_occ3",  {30'b0, occ3}, 32'd3);
    check("stall_data1", d1, 32'd4);

    // Bubble with ctrl=F, then two real instructions.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'h55);
    check("adv_data3", d3, 32'd3);
    check("adv_occ3",  {30'b0, occ3}, 32'd2);
    check("bub_ctrl1", {28'b0, c1}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 32'd6);
    check("adv2_data3", d3, 32'd4);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 32'd7);
    check("bub_valid3", {31'b0, v3}, 32'h0);
    check("bub_ctrl3",  {28'b0, c3}, 32'h0);
    check("bub_data3",  d3, 32'h55);
    check("bub_occ3",   {30'b0, occ3}, 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 32'd8);
    check("full_data3", d3, 32'd6);
    check("full_ctrl3", {28'b0, c3}, 32'h6);

    // Flush and stall together: flush wins.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hC, 32'hAB);
    check("fl_valid3", {31'b0, v3}, 32'h0);
    check("fl_ctrl3",  {28'b0, c3}, 32'h0);
    check("fl_data3",  d3, 32'd6);
    check("fl_occ3",   {30'b0, occ3}, 32'h0);
    check("fl_data1",  d1, 32'h0);
    check("fl_occ1",   {31'b0, occ1}, 32'h0);

    // Refill after flush: first valid output after DEPTH cycles.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 32'h10);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 32'h11);
    check("rf_valid3", {31'b0, v3}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 32'h12);
    check("rf_data3",  d3, 32'h10);
    check("rf_occ3",   {30'b0, occ3}, 32'd3);

`ifdef PIPE_PERF_CNT_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 32'h33);
    check("pc_stall3", sc3, 32'd5);
    check("pc_bub3",   bc3, 32'd5);
    check("pc_stall1", sc1, 32'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 32'h33);
    check("pc_rst_stall3", sc3, 32'd0);
    check("pc_rst_bub3",   bc3, 32'd0);
    check("pc_rst_occ3",   {30'b0, occ3}, 32'd0);
`endif

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
